// File: rtl/booth_r4_acc_ctrl.sv
// Radix-4 Booth control and high-half accumulator beside an external 2-bit-per-shift multiplier register.
// Optional BOOTH_SKIP_ZERO_EN folds zero-digit iterations into a single cycle.
module booth_r4_acc_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [WIDTH-1:0] mcand_i,
    input  logic [1:0]       q_lo_i,
    output logic             sr_clr_o,
    output logic             sr_ld_o,
    output logic             sr_shift_o,
    output logic [1:0]       sr_shift_in_o,
    output logic [WIDTH-1:0] prod_hi_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int AW   = WIDTH + 2;
    localparam int ITER = WIDTH / 2;
    localparam int CW   = $clog2(ITER + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ADD   = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic signed [AW-1:0]  a_q, a_d;
    logic signed [AW-1:0]  m_q, m_d;
    logic                  qm1_q, qm1_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  clr_q, clr_d;

    logic [2:0]            digit_s;
    logic [AW-1:0]         addend_s;
    logic [AW-1:0]         sum_s;
    logic                  last_s;

    // Booth digit times M, kept modulo 2^AW; the two guard bits make -2M of the most negative operand fit.
    function automatic logic [AW-1:0] booth_addend(input logic [2:0] dig, input logic [AW-1:0] m);
        logic [AW-1:0] m2;
        m2 = {m[AW-2:0], 1'b0};
        case (dig)
            3'b001, 3'b010: booth_addend = m;
            3'b011:         booth_addend = m2;
            3'b100:         booth_addend = ~m2 + AW'(1);
            3'b101, 3'b110: booth_addend = ~m + AW'(1);
            default:        booth_addend = '0;
        endcase
    endfunction

    assign digit_s  = {q_lo_i, qm1_q};
    assign addend_s = booth_addend(digit_s, m_q);
    assign sum_s    = a_q + addend_s;
    assign last_s   = (cnt_q == CW'(ITER - 1));

`ifdef BOOTH_SKIP_ZERO_EN
    logic zero_digit_s;
    assign zero_digit_s = (digit_s == 3'b000) || (digit_s == 3'b111);
`endif

    // Next-state and datapath update; abort overrides every state including a start in IDLE.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        m_d     = m_q;
        qm1_d   = qm1_q;
        cnt_d   = cnt_q;
        clr_d   = 1'b0;
        if (abort_i) begin
            state_d = S_IDLE;
            a_d     = '0;
            clr_d   = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        m_d     = {{2{mcand_i[WIDTH-1]}}, mcand_i};
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_LOAD: begin
                    a_d     = '0;
                    qm1_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_ADD;
                end
                S_ADD: begin
`ifdef BOOTH_SKIP_ZERO_EN
                    if (zero_digit_s) begin
                        a_d     = a_q >>> 2;
                        qm1_d   = q_lo_i[1];
                        cnt_d   = cnt_q + CW'(1);
                        state_d = last_s ? S_DONE : S_ADD;
                    end else begin
                        a_d     = sum_s;
                        state_d = S_SHIFT;
                    end
`else
                    a_d     = sum_s;
                    state_d = S_SHIFT;
`endif
                end
                S_SHIFT: begin
                    a_d     = a_q >>> 2;
                    qm1_d   = q_lo_i[1];
                    cnt_d   = cnt_q + CW'(1);
                    state_d = last_s ? S_DONE : S_ADD;
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            m_q     <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            m_q     <= m_d;
            qm1_q   <= qm1_d;
            cnt_q   <= cnt_d;
            clr_q   <= clr_d;
        end
    end

    // The clear pulse only ever lands in IDLE, which keeps it exclusive of load and shift.
    assign sr_clr_o      = clr_q;
    assign sr_ld_o       = (state_q == S_LOAD);
`ifdef BOOTH_SKIP_ZERO_EN
    assign sr_shift_o    = (state_q == S_SHIFT) || ((state_q == S_ADD) && zero_digit_s);
`else
    assign sr_shift_o    = (state_q == S_SHIFT);
`endif
    assign sr_shift_in_o = a_q[1:0];
    assign prod_hi_o     = a_q[WIDTH-1:0];
    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = (state_q == S_DONE);

endmodule
